// File: rtl/rdma_rc_psn_tagger.sv
// rdma_rc_psn_tagger
//   Transmit-side RC stage sitting directly after the RC send buffer. For
//   every buffered packet it emits one 64-bit transport header beat
//   {opcode 8'h04, QPN, PSN, 8'h00}, then passes the payload through with
//   no added latency. PSNs are assigned sequentially and wrap at 2^24.
//   Unacknowledged packets are counted against cumulative ACKs, and
//   send_pause is raised when the outstanding window is full.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cfg_qpn             destination QPN, captured into each header
//   cfg_start_psn       initial PSN, loaded by the cfg_load pulse
//   cfg_load            load strobe; only honoured when idle with nothing outstanding
//   s_axis_*            payload stream from the send buffer
//   m_axis_*            header + payload stream to the link
//   ack_valid, ack_psn  cumulative ACK (inclusive highest PSN)
//   ack_err             one-cycle pulse for a rejected ACK
//   send_pause          window full, fed back to the send buffer
//   outstanding         unacknowledged packet count
//   next_psn            PSN to be used by the next packet
module rdma_rc_psn_tagger #(
    parameter int DATA_WIDTH = 64,
    parameter int PSN_WIDTH  = 24,
    parameter int WINDOW     = 8,
    parameter int CNT_WIDTH  = $clog2(WINDOW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PSN_WIDTH-1:0]  cfg_qpn,
    input  logic [PSN_WIDTH-1:0]  cfg_start_psn,
    input  logic                  cfg_load,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  ack_valid,
    input  logic [PSN_WIDTH-1:0]  ack_psn,
    output logic                  ack_err,
    output logic                  send_pause,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic [PSN_WIDTH-1:0]  next_psn
);

    localparam logic [7:0]           HDR_OPCODE = 8'h04;
    localparam logic [CNT_WIDTH-1:0] WIN_C      = CNT_WIDTH'(WINDOW);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [PSN_WIDTH-1:0]  next_psn_q, next_psn_d;
    logic [PSN_WIDTH-1:0]  oldest_q, oldest_d;
    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic                  send_pause_q;
    logic                  ack_err_q;

    logic                  commit;
    logic                  ack_ok;
    logic [PSN_WIDTH-1:0]  ack_n;
    logic [PSN_WIDTH-1:0]  cnt_ext;

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        next_psn_d    = next_psn_q;
        oldest_d      = oldest_q;
        commit        = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;

        case (state_q)
            IDLE: begin
                if (cfg_load && outstanding_q == '0) begin
                    next_psn_d = cfg_start_psn;
                    oldest_d   = cfg_start_psn;
                end
                // Window is only checked here; an admitted packet always completes.
                if (s_axis_tvalid && outstanding_q < WIN_C) begin
                    hdr_d   = {HDR_OPCODE, cfg_qpn, next_psn_q, 8'h00};
                    state_d = HDR;
                end
            end
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_q;
                if (m_axis_tready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    commit     = 1'b1;
                    next_psn_d = next_psn_q + PSN_WIDTH'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cumulative ACK: number of packets it retires, modulo the PSN space.
        // Judged against the registered count, before any same-cycle commit.
        ack_n   = ack_psn - oldest_q + PSN_WIDTH'(1);
        cnt_ext = PSN_WIDTH'(outstanding_q);
        ack_ok  = ack_valid && (ack_n != '0) && (ack_n <= cnt_ext);
        if (ack_ok) begin
            oldest_d = ack_psn + PSN_WIDTH'(1);
        end

        outstanding_d = outstanding_q
                      + (commit ? CNT_WIDTH'(1) : '0)
                      - (ack_ok ? ack_n[CNT_WIDTH-1:0] : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hdr_q         <= '0;
            next_psn_q    <= '0;
            oldest_q      <= '0;
            outstanding_q <= '0;
            send_pause_q  <= 1'b0;
            ack_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            next_psn_q    <= next_psn_d;
            oldest_q      <= oldest_d;
            outstanding_q <= outstanding_d;
            // Derived from the next count so it never lags outstanding.
            send_pause_q  <= (outstanding_d == WIN_C);
            ack_err_q     <= ack_valid && !ack_ok;
        end
    end

    assign outstanding = outstanding_q;
    assign next_psn    = next_psn_q;
    assign send_pause  = send_pause_q;
    assign ack_err     = ack_err_q;

endmodule
